// File: rtl/bhargava_core.sv
// bhargava_core: transparent MPEG byte path of the Bhargava scrambler.
// Incoming bytes are buffered in an on-chip FIFO and returned unchanged, in order,
// through a pull interface. A start-code scanner counts video PES headers.
// The core also keeps throughput counters. The scrambling-stage debug ports
// are present so the port list matches the full core, but they read as zero.
module bhargava_core #(
  parameter int ADDR_W           = 10,
  parameter int PROG_FULL_THRESH = 896
) (
  input  logic        clk,
  input  logic        rst_n_200,
  input  logic        clk_en,
  input  logic [7:0]  mpeg_in,
  input  logic        mpeg_in_en,
  input  logic        stream_end,
  input  logic        mpeg_rd,
  output logic [7:0]  mpeg_out,
  output logic        mpeg_empty,
  output logic        mpeg_prog_full,
  output logic [31:0] vid_cnt,
  output logic [31:0] misc_in_cnt,
  output logic [31:0] vbuf_out_cnt,
  output logic [31:0] vlc_cnt_bit,
  output logic [28:0] vlc_cnt_byte,
  output logic [2:0]  vlc_cnt_rem,
  output logic [31:0] ex_cnt_cnt,
  output logic [28:0] ex_cnt_byte,
  output logic [2:0]  ex_cnt_rem,
  output logic [31:0] sign_cnt_cnt,
  output logic [28:0] sign_cnt_byte,
  output logic [2:0]  sign_cnt_rem,
  output logic [31:0] sign_switch_cnt,
  output logic [28:0] sign_switch_byte,
  output logic [2:0]  sign_switch_rem,
  output logic [31:0] replacer_in_cnt,
  output logic [31:0] replacer_out_cnt,
  output logic [31:0] pos_sign_cnt,
  output logic [31:0] neg_sign_cnt,
  output logic        pos_sign_bit,
  output logic        neg_sign_bit
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PF_LVL   = PROG_FULL_THRESH[ADDR_W:0];

  typedef enum logic [1:0] {
    SCAN_IDLE,
    SCAN_Z1,
    SCAN_Z2,
    SCAN_SC
  } scan_state_t;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_next;
  logic              full;
  logic              wr_ok;
  logic              rd_ok;
  scan_state_t       scan_state;
  logic              unused_stream_end;

  // stream_end is informational only; the FIFO keeps draining regardless
  assign unused_stream_end = stream_end;

  // A read at full frees the slot the simultaneous write lands in
  assign full  = (count == FULL_LVL);
  assign rd_ok = clk_en & mpeg_rd & ~mpeg_empty;
  assign wr_ok = clk_en & mpeg_in_en & (~full | rd_ok);

  // Next occupancy: write-only grows, read-only shrinks, both or neither holds
  always_comb begin
    count_next = count;
    if (wr_ok && !rd_ok) begin
      count_next = count + 1'b1;
    end else if (rd_ok && !wr_ok) begin
      count_next = count - 1'b1;
    end
  end

  // Byte storage has no reset; only the pointers decide what is valid
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= mpeg_in;
    end
  end

  // Pointers, occupancy, registered flags and the popped output byte
  always_ff @(posedge clk or negedge rst_n_200) begin
    if (!rst_n_200) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      mpeg_empty     <= 1'b1;
      mpeg_prog_full <= 1'b0;
      mpeg_out       <= 8'h00;
    end else if (clk_en) begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr   <= rd_ptr + 1'b1;
        mpeg_out <= mem[rd_ptr];
      end
      count          <= count_next;
      mpeg_empty     <= (count_next == '0);
      mpeg_prog_full <= (count_next >= PF_LVL);
    end
  end

  // Throughput counters for accepted and popped bytes, wrapping at 2**32
  always_ff @(posedge clk or negedge rst_n_200) begin
    if (!rst_n_200) begin
      misc_in_cnt  <= '0;
      vbuf_out_cnt <= '0;
      vlc_cnt_bit  <= '0;
    end else if (clk_en) begin
      if (wr_ok) begin
        misc_in_cnt <= misc_in_cnt + 32'd1;
      end
      if (rd_ok) begin
        vbuf_out_cnt <= vbuf_out_cnt + 32'd1;
        vlc_cnt_bit  <= vlc_cnt_bit + 32'd8;
      end
    end
  end

  // Start-code scanner over accepted bytes: counts 00 00 01 E0..EF headers
  always_ff @(posedge clk or negedge rst_n_200) begin
    if (!rst_n_200) begin
      scan_state <= SCAN_IDLE;
      vid_cnt    <= '0;
    end else if (wr_ok) begin
      case (scan_state)
        SCAN_IDLE: scan_state <= (mpeg_in == 8'h00) ? SCAN_Z1 : SCAN_IDLE;
        SCAN_Z1:   scan_state <= (mpeg_in == 8'h00) ? SCAN_Z2 : SCAN_IDLE;
        SCAN_Z2: begin
          if (mpeg_in == 8'h00) begin
            scan_state <= SCAN_Z2;
          end else if (mpeg_in == 8'h01) begin
            scan_state <= SCAN_SC;
          end else begin
            scan_state <= SCAN_IDLE;
          end
        end
        SCAN_SC: begin
          if (mpeg_in[7:4] == 4'hE) begin
            vid_cnt <= vid_cnt + 32'd1;
          end
          scan_state <= (mpeg_in == 8'h00) ? SCAN_Z1 : SCAN_IDLE;
        end
        default: scan_state <= SCAN_IDLE;
      endcase
    end
  end

  // Scrambling-stage statistics do not exist in this build
  assign ex_cnt_cnt       = '0;
  assign sign_cnt_cnt     = '0;
  assign sign_switch_cnt  = '0;
  assign replacer_in_cnt  = '0;
  assign replacer_out_cnt = '0;
  assign pos_sign_cnt     = '0;
  assign neg_sign_cnt     = '0;
  assign pos_sign_bit     = 1'b0;
  assign neg_sign_bit     = 1'b0;

  assign vlc_cnt_byte     = vlc_cnt_bit[31:3];
  assign vlc_cnt_rem      = vlc_cnt_bit[2:0];
  assign ex_cnt_byte      = ex_cnt_cnt[31:3];
  assign ex_cnt_rem       = ex_cnt_cnt[2:0];
  assign sign_cnt_byte    = sign_cnt_cnt[31:3];
  assign sign_cnt_rem     = sign_cnt_cnt[2:0];
  assign sign_switch_byte = sign_switch_cnt[31:3];
  assign sign_switch_rem  = sign_switch_cnt[2:0];

endmodule

// File: tb/tb_bhargava_core.sv
// Directed testbench for bhargava_core: reset, single byte, fill/overflow/drain,
// simultaneous read+write, start-code counting, clock enable and paced replay.
module tb_bhargava_core;

  logic        clk;
  logic        rst_n_200;
  logic        clk_en;
  logic [7:0]  mpeg_in;
  logic        mpeg_in_en;
  logic        stream_end;
  logic        mpeg_rd;
  logic [7:0]  mpeg_out;
  logic        mpeg_empty;
  logic        mpeg_prog_full;
  logic [31:0] vid_cnt, misc_in_cnt, vbuf_out_cnt, vlc_cnt_bit;
  logic [28:0] vlc_cnt_byte, ex_cnt_byte, sign_cnt_byte, sign_switch_byte;
  logic [2:0]  vlc_cnt_rem, ex_cnt_rem, sign_cnt_rem, sign_switch_rem;
  logic [31:0] ex_cnt_cnt, sign_cnt_cnt, sign_switch_cnt;
  logic [31:0] replacer_in_cnt, replacer_out_cnt, pos_sign_cnt, neg_sign_cnt;
  logic        pos_sign_bit, neg_sign_bit;

  int vectors;
  int miscompares;

  bhargava_core dut (
    .clk              (clk),
    .rst_n_200        (rst_n_200),
    .clk_en           (clk_en),
    .mpeg_in          (mpeg_in),
    .mpeg_in_en       (mpeg_in_en),
    .stream_end       (stream_end),
    .mpeg_rd          (mpeg_rd),
    .mpeg_out         (mpeg_out),
    .mpeg_empty       (mpeg_empty),
    .mpeg_prog_full   (mpeg_prog_full),
    .vid_cnt          (vid_cnt),
    .misc_in_cnt      (misc_in_cnt),
    .vbuf_out_cnt     (vbuf_out_cnt),
    .vlc_cnt_bit      (vlc_cnt_bit),
    .vlc_cnt_byte     (vlc_cnt_byte),
    .vlc_cnt_rem      (vlc_cnt_rem),
    .ex_cnt_cnt       (ex_cnt_cnt),
    .ex_cnt_byte      (ex_cnt_byte),
    .ex_cnt_rem       (ex_cnt_rem),
    .sign_cnt_cnt     (sign_cnt_cnt),
    .sign_cnt_byte    (sign_cnt_byte),
    .sign_cnt_rem     (sign_cnt_rem),
    .sign_switch_cnt  (sign_switch_cnt),
    .sign_switch_byte (sign_switch_byte),
    .sign_switch_rem  (sign_switch_rem),
    .replacer_in_cnt  (replacer_in_cnt),
    .replacer_out_cnt (replacer_out_cnt),
    .pos_sign_cnt     (pos_sign_cnt),
    .neg_sign_cnt     (neg_sign_cnt),
    .pos_sign_bit     (pos_sign_bit),
    .neg_sign_bit     (neg_sign_bit)
  );

  // 10 ns system clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n_200  = 1'b0;
    mpeg_in_en = 1'b0;
    mpeg_rd    = 1'b0;
    mpeg_in    = 8'h00;
    clk_en     = 1'b1;
    step();
    step();
    rst_n_200 = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    rst_n_200 = 1'b0;
    #1;
    vectors++;
    if (mpeg_empty !== 1'b1 || mpeg_prog_full !== 1'b0 || mpeg_out !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: empty=%b pf=%b out=%h, want 1 0 00", mpeg_empty, mpeg_prog_full, mpeg_out);
    end
    vectors++;
    if (vid_cnt !== 0 || misc_in_cnt !== 0 || vbuf_out_cnt !== 0 || vlc_cnt_bit !== 0) begin
      miscompares++;
      $display("[TB] FAIL reset_counters: vid=%0d in=%0d out=%0d bits=%0d, want all 0",
               vid_cnt, misc_in_cnt, vbuf_out_cnt, vlc_cnt_bit);
    end
    vectors++;
    if (ex_cnt_cnt !== 0 || sign_switch_byte !== 0 || pos_sign_bit !== 1'b0 || replacer_out_cnt !== 0) begin
      miscompares++;
      $display("[TB] FAIL reset_tied: ex=%0d ssb=%0d psb=%b rep=%0d, want 0",
               ex_cnt_cnt, sign_switch_byte, pos_sign_bit, replacer_out_cnt);
    end
    step();
    rst_n_200 = 1'b1;
    step();
  endtask

  task automatic test_single_byte();
    do_reset();
    mpeg_in    = 8'hA5;
    mpeg_in_en = 1'b1;
    step();
    mpeg_in_en = 1'b0;
    vectors++;
    if (mpeg_empty !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_empty_clear: got %b want 0", mpeg_empty);
    end
    mpeg_rd = 1'b1;
    step();
    mpeg_rd = 1'b0;
    vectors++;
    if (mpeg_out !== 8'hA5 || mpeg_empty !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_pop: out=%h empty=%b, want A5 1", mpeg_out, mpeg_empty);
    end
    vectors++;
    if (misc_in_cnt !== 32'd1 || vbuf_out_cnt !== 32'd1 || vlc_cnt_bit !== 32'd8 ||
        vlc_cnt_byte !== 29'd1 || vlc_cnt_rem !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL single_counts: in=%0d out=%0d bits=%0d byte=%0d rem=%0d, want 1 1 8 1 0",
               misc_in_cnt, vbuf_out_cnt, vlc_cnt_bit, vlc_cnt_byte, vlc_cnt_rem);
    end
    // pop while empty must be ignored
    mpeg_rd = 1'b1;
    step();
    mpeg_rd = 1'b0;
    vectors++;
    if (vbuf_out_cnt !== 32'd1 || mpeg_out !== 8'hA5 || mpeg_empty !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pop_when_empty: out_cnt=%0d out=%h empty=%b, want 1 A5 1",
               vbuf_out_cnt, mpeg_out, mpeg_empty);
    end
  endtask

  task automatic test_occ_one_rw();
    do_reset();
    mpeg_in    = 8'h11;
    mpeg_in_en = 1'b1;
    step();
    mpeg_in = 8'h22;
    mpeg_rd = 1'b1;
    step();
    mpeg_in_en = 1'b0;
    vectors++;
    if (mpeg_out !== 8'h11 || mpeg_empty !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rw_occ1: out=%h empty=%b, want 11 0", mpeg_out, mpeg_empty);
    end
    step();
    mpeg_rd = 1'b0;
    vectors++;
    if (mpeg_out !== 8'h22 || mpeg_empty !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rw_occ1_tail: out=%h empty=%b, want 22 1", mpeg_out, mpeg_empty);
    end
  endtask

  task automatic test_fill_drain();
    int bad;
    logic [7:0] want;
    do_reset();
    mpeg_in_en = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      mpeg_in = 8'(i);
      step();
      if (i == 894) begin
        vectors++;
        if (mpeg_prog_full !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL prog_full_895: got %b want 0", mpeg_prog_full);
        end
      end
      if (i == 895) begin
        vectors++;
        if (mpeg_prog_full !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL prog_full_896: got %b want 1", mpeg_prog_full);
        end
      end
    end
    // 1025th byte while full is dropped
    mpeg_in = 8'h55;
    step();
    vectors++;
    if (misc_in_cnt !== 32'd1024) begin
      miscompares++;
      $display("[TB] FAIL overflow_drop: in_cnt=%0d want 1024", misc_in_cnt);
    end
    // write+read at full: head byte 00 leaves, 77 joins the tail
    mpeg_in = 8'h77;
    mpeg_rd = 1'b1;
    step();
    mpeg_in_en = 1'b0;
    vectors++;
    if (mpeg_out !== 8'h00 || misc_in_cnt !== 32'd1025 || mpeg_prog_full !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rw_full: out=%h in_cnt=%0d pf=%b, want 00 1025 1", mpeg_out, misc_in_cnt, mpeg_prog_full);
    end
    bad = 0;
    for (int k = 1; k <= 1024; k++) begin
      want = (k == 1024) ? 8'h77 : 8'(k);
      step();
      if (mpeg_out !== want) begin
        if (bad < 4) $display("[TB] FAIL drain_order: pop %0d out=%h want %h", k, mpeg_out, want);
        bad++;
      end
    end
    mpeg_rd = 1'b0;
    vectors++;
    if (bad != 0) miscompares++;
    vectors++;
    if (mpeg_empty !== 1'b1 || mpeg_prog_full !== 1'b0 || vbuf_out_cnt !== 32'd1025) begin
      miscompares++;
      $display("[TB] FAIL drain_end: empty=%b pf=%b out_cnt=%0d, want 1 0 1025",
               mpeg_empty, mpeg_prog_full, vbuf_out_cnt);
    end
  endtask

  task automatic test_start_codes();
    logic [7:0] pat [13];
    pat = '{8'h00, 8'h00, 8'h01, 8'hE0,
            8'h00, 8'h00, 8'h00, 8'h01, 8'hE5,
            8'h00, 8'h00, 8'h01, 8'hBA};
    do_reset();
    mpeg_in_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      mpeg_in = pat[i];
      step();
    end
    mpeg_in_en = 1'b0;
    vectors++;
    if (vid_cnt !== 32'd2 || misc_in_cnt !== 32'd13) begin
      miscompares++;
      $display("[TB] FAIL start_codes: vid=%0d in=%0d, want 2 13", vid_cnt, misc_in_cnt);
    end
  endtask

  task automatic test_clk_en();
    do_reset();
    clk_en     = 1'b0;
    mpeg_in    = 8'h3C;
    mpeg_in_en = 1'b1;
    step();
    step();
    mpeg_in_en = 1'b0;
    vectors++;
    if (mpeg_empty !== 1'b1 || misc_in_cnt !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL clk_en_freeze: empty=%b in=%0d, want 1 0", mpeg_empty, misc_in_cnt);
    end
    clk_en = 1'b1;
  endtask

  task automatic test_replay_and_reset();
    logic [7:0] src [8];
    int popped;
    int wait_cyc;
    logic [7:0] want;
    src = '{8'h00, 8'h00, 8'h01, 8'hE3, 8'h47, 8'hFF, 8'h80, 8'h1F};
    do_reset();
    stream_end = 1'b0;
    popped = 0;
    for (int i = 0; i < 8; i++) begin
      mpeg_in    = src[i];
      mpeg_in_en = 1'b1;
      step();
      mpeg_in_en = 1'b0;
      for (int c = 0; c < 127; c++) begin
        mpeg_rd = ~mpeg_empty;
        step();
        if (mpeg_rd) begin
          want = src[popped];
          vectors++;
          if (mpeg_out !== want) begin
            miscompares++;
            $display("[TB] FAIL replay_byte%0d: out=%h want %h", popped, mpeg_out, want);
          end
          popped++;
        end
      end
      mpeg_rd = 1'b0;
    end
    stream_end = 1'b1;
    vectors++;
    if (popped != 8 || vid_cnt !== 32'd1 || mpeg_empty !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL replay_totals: popped=%0d vid=%0d empty=%b, want 8 1 1", popped, vid_cnt, mpeg_empty);
    end
    // fill a few bytes, then reset mid-stream
    mpeg_in_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mpeg_in = 8'(8'h90 + i);
      step();
    end
    mpeg_in_en = 1'b0;
    mpeg_rd    = 1'b1;
    step();
    mpeg_rd = 1'b0;
    wait_cyc = 0;
    rst_n_200 = 1'b0;
    #1;
    vectors++;
    if (mpeg_empty !== 1'b1 || mpeg_out !== 8'h00 || misc_in_cnt !== 0 || vbuf_out_cnt !== 0) begin
      miscompares++;
      $display("[TB] FAIL midstream_reset: empty=%b out=%h in=%0d out_cnt=%0d, want 1 00 0 0",
               mpeg_empty, mpeg_out, misc_in_cnt, vbuf_out_cnt);
    end
    step();
    rst_n_200 = 1'b1;
    step();
    mpeg_rd = 1'b1;
    step();
    mpeg_rd = 1'b0;
    vectors++;
    if (mpeg_empty !== 1'b1 || vbuf_out_cnt !== 0 || wait_cyc != 0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_empty: empty=%b out_cnt=%0d, want 1 0", mpeg_empty, vbuf_out_cnt);
    end
    stream_end = 1'b0;
  endtask

  // Run every scenario in order, then report
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n_200   = 1'b0;
    clk_en      = 1'b1;
    mpeg_in     = 8'h00;
    mpeg_in_en  = 1'b0;
    stream_end  = 1'b0;
    mpeg_rd     = 1'b0;
    test_reset();
    test_single_byte();
    test_occ_one_rw();
    test_fill_drain();
    test_start_codes();
    test_clk_en();
    test_replay_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
